// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision FP definitions for the multiplier datapath
// and the downstream exception stage.
//   round_t  : rounding-mode encoding (codes 6 and 7 are undefined)
//   BIAS     : exponent bias
//   EXP_MAX  : largest finite biased exponent
//   prod_t   : stage-1 register contents (unpacked product)
//   res_t    : stage-2/3 register contents (rounded result + forwarded inputs)
package fp_pkg;

  typedef enum logic [2:0] {
    IEEE_NEAR = 3'd0,
    IEEE_ZERO = 3'd1,
    IEEE_PINF = 3'd2,
    IEEE_NINF = 3'd3,
    NEAR_UP   = 3'd4,
    AWAY_ZERO = 3'd5
  } round_t;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 254;

  typedef struct packed {
    logic               sign;
    logic signed [9:0]  e;
    logic        [47:0] p;
    logic        [31:0] a;
    logic        [31:0] b;
    logic        [2:0]  round;
  } prod_t;

  typedef struct packed {
    logic [31:0] z;
    logic        ovf;
    logic        unf;
    logic        inexact;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  round;
  } res_t;

endpackage

// File: rtl/fp_mult_core_if.sv
// fp_mult_core_if: valid/ready bundle around fp_mult_core.
//   in_valid/in_ready, a, b, round          : operand side
//   out_valid/out_ready, z_calc, ovf, unf,
//   inexact, a_o, b_o, round_o              : result side
// master = producer/consumer environment, slave = the core.
interface fp_mult_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  round;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z_calc;
  logic        ovf;
  logic        unf;
  logic        inexact;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [2:0]  round_o;

  modport master (
    output in_valid, a, b, round, out_ready,
    input  in_ready, out_valid, z_calc, ovf, unf, inexact, a_o, b_o, round_o
  );

  modport slave (
    input  in_valid, a, b, round, out_ready,
    output in_ready, out_valid, z_calc, ovf, unf, inexact, a_o, b_o, round_o
  );
endinterface

// File: rtl/fp_round.sv
// fp_round: combinational rounding of a normalized 24-bit significand.
//   mant   : 23 fraction bits (hidden one implied)
//   g, s   : guard and sticky bits
//   sign   : result sign (directed modes)
//   mode   : rounding mode, fp_pkg::round_t encoding; 6/7 truncate
//   mant_r : rounded fraction
//   carry  : increment overflowed the significand (result becomes 2.0)
module fp_round
  import fp_pkg::*;
(
  input  logic [22:0] mant,
  input  logic        g,
  input  logic        s,
  input  logic        sign,
  input  logic [2:0]  mode,
  output logic [22:0] mant_r,
  output logic        carry
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (mode)
      IEEE_NEAR: inc = g & (s | mant[0]);
      IEEE_ZERO: inc = 1'b0;
      IEEE_PINF: inc = (g | s) & ~sign;
      IEEE_NINF: inc = (g | s) & sign;
      NEAR_UP:   inc = g;
      AWAY_ZERO: inc = g | s;
      default:   inc = 1'b0;
    endcase
  end

  // With the hidden one fixed at 1, the 24-bit significand overflows exactly
  // when the 23-bit fraction overflows; the fraction then wraps to zero.
  assign {carry, mant_r} = {1'b0, mant} + {23'd0, inc};

endmodule

// File: rtl/fp_mult_core.sv
// fp_mult_core: pipelined IEEE-754 single-precision multiplier datapath.
// Produces the rounded product with an unclamped exponent plus ovf/unf/inexact,
// and forwards a, b, round aligned with the result for exception_mult.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : fp_mult_core_if.slave (operand and result valid/ready handshakes)
// Build option: FP_MULT_OUT_REG_EN adds a third register stage (latency 3);
// without it the stage-2 registers drive the outputs (latency 2).
// The whole pipeline advances together: adv = !out_valid || out_ready.
module fp_mult_core
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fp_mult_core_if.slave  bus
);

  logic  adv;
  logic  o_v;
  res_t  o_q;

  logic  s1_v;
  prod_t s1_d, s1_q;
  logic  s2_v;
  res_t  s2_d, s2_q;

  assign adv          = ~o_v | bus.out_ready;
  assign bus.in_ready = adv;

  // Stage 1: sign, biased exponent sum, full significand product.
  always_comb begin
    s1_d       = '0;
    s1_d.sign  = bus.a[31] ^ bus.b[31];
    s1_d.e     = {2'b00, bus.a[30:23]} + {2'b00, bus.b[30:23]} - 10'(BIAS);
    s1_d.p     = {24'd0, 1'b1, bus.a[22:0]} * {24'd0, 1'b1, bus.b[22:0]};
    s1_d.a     = bus.a;
    s1_d.b     = bus.b;
    s1_d.round = bus.round;
  end

  // Stage 2: normalize, round, flag.
  logic              norm;
  logic [22:0]       mant;
  logic              g;
  logic              s;
  logic [22:0]       mant_r;
  logic              carry;
  logic signed [9:0] e_n;
  logic signed [9:0] e_f;

  always_comb begin
    norm = s1_q.p[47];
    mant = norm ? s1_q.p[46:24] : s1_q.p[45:23];
    g    = norm ? s1_q.p[23]    : s1_q.p[22];
    s    = norm ? |s1_q.p[22:0] : |s1_q.p[21:0];
  end

  fp_round u_round (
    .mant   (mant),
    .g      (g),
    .s      (s),
    .sign   (s1_q.sign),
    .mode   (s1_q.round),
    .mant_r (mant_r),
    .carry  (carry)
  );

  always_comb begin
    e_n          = s1_q.e + {9'd0, norm};
    e_f          = e_n + {9'd0, carry};
    s2_d         = '0;
    s2_d.z       = {s1_q.sign, e_f[7:0], mant_r};
    s2_d.ovf     = e_f > $signed(10'(EXP_MAX));
    s2_d.unf     = e_f < 10'sd1;
    s2_d.inexact = g | s;
    s2_d.a       = s1_q.a;
    s2_d.b       = s1_q.b;
    s2_d.round   = s1_q.round;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v <= 1'b0;
      s1_q <= '0;
      s2_v <= 1'b0;
      s2_q <= '0;
    end else if (adv) begin
      s1_v <= bus.in_valid;
      s1_q <= s1_d;
      s2_v <= s1_v;
      s2_q <= s2_d;
    end
  end

`ifdef FP_MULT_OUT_REG_EN
  logic s3_v;
  res_t s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_v <= 1'b0;
      s3_q <= '0;
    end else if (adv) begin
      s3_v <= s2_v;
      s3_q <= s2_q;
    end
  end

  assign o_v = s3_v;
  assign o_q = s3_q;
`else
  assign o_v = s2_v;
  assign o_q = s2_q;
`endif

  assign bus.out_valid = o_v;
  assign bus.z_calc    = o_q.z;
  assign bus.ovf       = o_q.ovf;
  assign bus.unf       = o_q.unf;
  assign bus.inexact   = o_q.inexact;
  assign bus.a_o       = o_q.a;
  assign bus.b_o       = o_q.b;
  assign bus.round_o   = o_q.round;

endmodule

// File: tb/tb_fp_mult_core.sv
// tb_fp_mult_core: self-checking bench for fp_mult_core. A behavioural model
// computes each product with plain integer arithmetic; a per-cycle monitor
// tracks in-flight items as a queue of ages and checks handshake and data.
module tb_fp_mult_core;
  import fp_pkg::*;

`ifdef FP_MULT_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_mult_core_if bus ();

  fp_mult_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  r;
    logic [34:0] res;
    int          age;
  } ent_t;

  ent_t q[$];
  bit   mon_en = 1'b0;
  int   popped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {ovf, unf, inexact, z_calc}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] r);
    longint unsigned ma, mb, p, sig, rem, half;
    int e, sh;
    bit sign, g, st, inc;
    sign = a[31] ^ b[31];
    ma   = {41'd0, 1'b1, a[22:0]};
    mb   = {41'd0, 1'b1, b[22:0]};
    p    = ma * mb;
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    sig  = p >> sh;
    rem  = p - (sig << sh);
    half = 64'd1 << (sh - 1);
    g    = rem >= half;
    st   = (rem != 0) && (rem != half);
    case (r)
      3'd0:    inc = g && (st || sig[0]);
      3'd2:    inc = (g || st) && !sign;
      3'd3:    inc = (g || st) && sign;
      3'd4:    inc = g;
      3'd5:    inc = g || st;
      default: inc = 1'b0;
    endcase
    sig = sig + 64'(inc);
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e   = e + 1;
    end
    return {e > 254, e < 1, g || st, sign, e[7:0], sig[22:0]};
  endfunction

  // Per-cycle monitor: expected out_valid is "oldest item has aged LAT cycles".
  always @(negedge clk) begin
    bit ev, adv_m;
    ent_t n;
    if (mon_en) begin
      ev    = (q.size() > 0) && (q[0].age == LAT);
      adv_m = !ev || bus.out_ready;
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("in_ready", 64'(bus.in_ready), 64'(adv_m));
      if (ev) begin
        chk("z_calc", 64'(bus.z_calc), 64'(q[0].res[31:0]));
        chk("flags", 64'({bus.ovf, bus.unf, bus.inexact}), 64'(q[0].res[34:32]));
        chk("forward", {bus.a_o, bus.b_o}, {q[0].a, q[0].b});
        chk("round_o", 64'(bus.round_o), 64'(q[0].r));
        if (bus.out_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
      if (bus.in_valid && adv_m) begin
        n.a   = bus.a;
        n.b   = bus.b;
        n.r   = bus.round;
        n.res = model(bus.a, bus.b, bus.round);
        n.age = 0;
        q.push_back(n);
      end
      if (adv_m) foreach (q[i]) q[i].age++;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    @(posedge clk);
    #1;
    bus.a        = a;
    bus.b        = b;
    bus.round    = r;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready low for 64 cycles expected accept");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Literal pin: checks the model and the DUT against a hand-computed value.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] r, input logic [31:0] ez, input logic [2:0] ef);
    int n;
    bit found;
    chk({name, "_model"}, 64'(model(a, b, r)), 64'({ef, ez}));
    bus.out_ready = 1'b1;
    send(a, b, r);
    found = 1'b0;
    n     = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) found = 1'b1;
    end
    chk({name, "_latency"}, 64'(n), 64'(LAT));
    chk({name, "_z"}, 64'(bus.z_calc), 64'(ez));
    chk({name, "_flags"}, 64'({bus.ovf, bus.unf, bus.inexact}), 64'(ef));
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int base;
    bit saw_low;
    bit done;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.round     = '0;

    // Reset state.
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_z", 64'(bus.z_calc), 64'd0);
    chk("rst_flags", 64'({bus.ovf, bus.unf, bus.inexact}), 64'd0);
    chk("rst_fwd", {bus.a_o, bus.b_o}, 64'd0);
    chk("rst_round_o", 64'(bus.round_o), 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Directed literal cases.
    run_one("mul_1p5x2",   32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 3'b000);
    run_one("ulp_near",    32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 3'b001);
    run_one("ulp_away",    32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800003, 3'b001);
    run_one("ulp_zero",    32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 3'b001);
    run_one("ovf",         32'h7F000000, 32'h7F000000, 3'd0, 32'h3E800000, 3'b100);
    run_one("unf",         32'h00800000, 32'h00800000, 3'd0, 32'h41800000, 3'b010);
    run_one("max_pinf",    32'h3FFFFFFF, 32'h3FFFFFFF, 3'd2, 32'h407FFFFF, 3'b001);
    run_one("carry_near",  32'h3FFFFFFE, 32'h3F800001, 3'd0, 32'h40000000, 3'b001);
    run_one("carry_zero",  32'h3FFFFFFE, 32'h3F800001, 3'd1, 32'h3FFFFFFF, 3'b001);
    run_one("carry_ninf",  32'hBFFFFFFE, 32'h3F800001, 3'd3, 32'hC0000000, 3'b001);
    run_one("carry_pinfn", 32'hBFFFFFFE, 32'h3F800001, 3'd2, 32'hBFFFFFFF, 3'b001);
    run_one("carry_up",    32'h3FFFFFFE, 32'h3F800001, 3'd4, 32'h40000000, 3'b001);
    run_one("code7",       32'h3FFFFFFE, 32'h3F800001, 3'd7, 32'h3FFFFFFF, 3'b001);

    // Back-pressure: 6 back-to-back inputs, out_ready low in cycles 3..5.
    base    = popped;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'h3F800000 + 32'(i * 32'h00012345), 32'h40100000 + 32'(i), 3'(i));
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          @(posedge clk);
          #1;
          bus.out_ready = !(c >= 3 && c <= 5);
          @(negedge clk);
          if (!bus.in_ready) saw_low = 1'b1;
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("bp_in_ready_dropped", 64'(saw_low), 64'd1);
    chk("bp_count", 64'(popped - base), 64'd6);

    // Reset with two results in flight.
    bus.out_ready = 1'b1;
    send(32'h40400000, 32'h40400000, 3'd0);
    send(32'h40A00000, 32'h3F000000, 3'd0);
    #2;
    mon_en = 1'b0;
    q.delete();
    base = popped;
    rst  = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_z", 64'(bus.z_calc), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_nothing_out", 64'(popped - base), 64'd0);
    send(32'h40400000, 32'h40400000, 3'd0);
    drain();
    chk("midrst_next_ok", 64'(popped - base), 64'd1);

    // Randomized traffic with random back-pressure.
    base = popped;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          send($urandom, $urandom, 3'($urandom_range(0, 7)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("rand_count", 64'(popped - base), 64'd300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
